// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - time-multiplexed 4-digit seven-segment scanner for BCD inputs
//
// Purpose:
//   Takes a snapshot of four BCD digits once per scan frame and drives a
//   common-anode 4-digit display one digit at a time.
//   Leading zeros can be blanked. An all-0xF snapshot means overflow, and the
//   display then shows a blinking dash pattern.
//
// Ports:
//   Clk              rising-edge clock
//   Reset            synchronous, active-high
//   BCD0..BCD3       ones..thousands digits (0-9 valid, 4'hF on all = overflow)
//   Anode[3:0]       digit enables, active-low, bit i = digit i
//   Seg[6:0]         {g,f,e,d,c,b,a}, active-low
//   DP               decimal point, active-low, always off
module bcd_display_scanner #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 16,
  parameter int LZB          = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] BCD0,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD3,
  output logic [3:0] Anode,
  output logic [6:0] Seg,
  output logic       DP
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic [TW-1:0] tick_q,  tick_d;
  logic [1:0]    idx_q,   idx_d;
  logic [15:0]   snap_q,  snap_d;
  logic [FW-1:0] fcnt_q,  fcnt_d;
  logic          blink_q, blink_d;
  logic          load_q,  load_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q,   seg_d;

  logic          slot_end;
  logic          frame_end;
  logic          ovf;
  logic [3:0]    digit;
  logic          lead_zero;

  function automatic logic [6:0] dec_glyph(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_E;
    endcase
    return s;
  endfunction

  assign slot_end  = (tick_q == TICK_LAST);
  assign frame_end = slot_end && (idx_q == 2'd3);
  assign ovf       = (snap_q == 16'hFFFF);
  assign digit     = snap_q[{idx_q, 2'b00} +: 4];

  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    lead_zero = 1'b0;
    case (idx_q)
      2'd3:    lead_zero = (snap_q[15:12] == 4'd0);
      2'd2:    lead_zero = (snap_q[15:8]  == 8'd0);
      2'd1:    lead_zero = (snap_q[15:4]  == 12'd0);
      default: lead_zero = 1'b0;
    endcase
  end

  always_comb begin
    tick_d  = tick_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    load_d  = load_q;
    anode_d = 4'hF;
    seg_d   = SEG_BLANK;

    if (load_q) begin
      // First cycle out of reset: capture inputs, keep the scan parked so
      // digit 0 then gets a full slot on the new snapshot.
      snap_d = {BCD3, BCD2, BCD1, BCD0};
      load_d = 1'b0;
    end else begin
      tick_d = slot_end ? '0 : tick_q + TW'(1);
      if (slot_end) idx_d = idx_q + 2'd1;
      if (frame_end) snap_d = {BCD3, BCD2, BCD1, BCD0};

      // Held at zero outside overflow so blinking always starts on the dash phase.
      if (!ovf) begin
        fcnt_d  = '0;
        blink_d = 1'b0;
      end else if (frame_end) begin
        if (fcnt_q == FCNT_LAST) begin
          fcnt_d  = '0;
          blink_d = ~blink_q;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end

      anode_d = ~(4'b0001 << idx_q);
      if (ovf)                          seg_d = blink_q ? SEG_BLANK : SEG_DASH;
      else if (digit > 4'd9)            seg_d = SEG_E;
      else if ((LZB != 0) && lead_zero) seg_d = SEG_BLANK;
      else                              seg_d = dec_glyph(digit);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tick_q  <= '0;
      idx_q   <= 2'd0;
      snap_q  <= 16'd0;
      fcnt_q  <= '0;
      blink_q <= 1'b0;
      load_q  <= 1'b1;
      anode_q <= 4'hF;
      seg_q   <= SEG_BLANK;
    end else begin
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      fcnt_q  <= fcnt_d;
      blink_q <= blink_d;
      load_q  <= load_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign Anode = anode_q;
  assign Seg   = seg_q;
  assign DP    = 1'b1;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

  localparam int RD = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] b0, b1, b2, b3;
  logic [3:0] an_l, an_n;
  logic [6:0] seg_l, seg_n;
  logic       dp_l, dp_n;

  always #5 clk = ~clk;

  bcd_display_scanner #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF), .LZB(1)) u_dut_lzb (
    .Clk(clk), .Reset(rst), .BCD0(b0), .BCD1(b1), .BCD2(b2), .BCD3(b3),
    .Anode(an_l), .Seg(seg_l), .DP(dp_l)
  );

  bcd_display_scanner #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF), .LZB(0)) u_dut_nolzb (
    .Clk(clk), .Reset(rst), .BCD0(b0), .BCD1(b1), .BCD2(b2), .BCD3(b3),
    .Anode(an_n), .Seg(seg_n), .DP(dp_n)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: time since the load cycle decides which digit is shown,
  // frames completed while in overflow decide the blink phase.
  logic [6:0] dec_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int         snap [4];
  int         pend;
  int         n;
  int         ovf_frames;
  logic [3:0] exp_an;
  logic [6:0] exp_seg_l, exp_seg_n;

  function automatic bit snap_ovf();
    return snap[0] == 15 && snap[1] == 15 && snap[2] == 15 && snap[3] == 15;
  endfunction

  function automatic logic [6:0] glyph(input int i, input bit lzb);
    bit lead;
    if (snap_ovf()) return (((ovf_frames / BF) % 2) == 1) ? 7'h7F : 7'h3F;
    if (snap[i] > 9) return 7'h06;
    lead = (i > 0);
    for (int j = i; j < 4; j++) if (snap[j] != 0) lead = 0;
    if (lzb && lead) return 7'h7F;
    return dec_tab[snap[i]];
  endfunction

  task automatic capture();
    snap[0] = int'(b0); snap[1] = int'(b1); snap[2] = int'(b2); snap[3] = int'(b3);
  endtask

  task automatic model_edge();
    int d;
    if (rst) begin
      pend = 1; n = 0; ovf_frames = 0;
      for (int k = 0; k < 4; k++) snap[k] = 0;
      exp_an = 4'hF; exp_seg_l = 7'h7F; exp_seg_n = 7'h7F;
    end else if (pend != 0) begin
      pend = 0;
      capture();
      exp_an = 4'hF; exp_seg_l = 7'h7F; exp_seg_n = 7'h7F;
    end else begin
      d = (n / RD) % 4;
      exp_an    = 4'(~(4'b0001 << d));
      exp_seg_l = glyph(d, 1'b1);
      exp_seg_n = glyph(d, 1'b0);
      n++;
      if (n % (4 * RD) == 0) begin
        if (snap_ovf()) ovf_frames++;
        capture();
        if (!snap_ovf()) ovf_frames = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("anode",      an_l,  exp_an);
    check("seg_lzb",    seg_l, exp_seg_l);
    check("anode_nlz",  an_n,  exp_an);
    check("seg_nolzb",  seg_n, exp_seg_n);
    check("dp",         {dp_l, dp_n}, 2'b11);
  endtask

  task automatic set_in(input int v3, input int v2, input int v1, input int v0);
    b3 = 4'(v3); b2 = 4'(v2); b1 = 4'(v1); b0 = 4'(v0);
  endtask

  initial begin
    int hold, kind, nd;
    int waited;
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    pend = 1; n = 0; ovf_frames = 0;
    for (int k = 0; k < 4; k++) snap[k] = 0;

    step(); step();
    check("reset_anode", an_l, 4'hF);
    check("reset_seg", seg_l, 7'h7F);

    // Reset release with zeros: first cycle blank, digit 0 shows 0 for RD cycles,
    // then digits 1-3 scan blanked.
    rst = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c == 1) begin
        check("rel_c1_anode", an_l, 4'hF);
        check("rel_c1_seg", seg_l, 7'h7F);
      end else if (c <= 5) begin
        check("rel_d0_anode", an_l, 4'hE);
        check("rel_d0_seg", seg_l, 7'h40);
      end else begin
        check("rel_scan_anode", an_l, (c <= 9) ? 4'hD : (c <= 13) ? 4'hB : 4'h7);
        check("rel_scan_seg", seg_l, 7'h7F);
      end
    end

    // Overflow: dash for BF frames, then blank for BF frames.
    rst = 1'b1; step();
    rst = 1'b0; set_in(15, 15, 15, 15);
    for (int c = 1; c <= 70; c++) begin
      step();
      if (c >= 2 && c <= 33)  check("ovf_dash", seg_l, 7'h3F);
      if (c >= 34 && c <= 65) check("ovf_blank", seg_l, 7'h7F);
    end
    set_in(0, 0, 0, 0);
    for (int c = 0; c < 40; c++) step();

    // Mid-slot reset at digit 2.
    waited = 0;
    while (!(((n / RD) % 4) == 2 && (n % RD) == 1) && waited < 100) begin
      step();
      waited++;
    end
    check("midrst_reached", (waited < 100), 1'b1);
    rst = 1'b1;
    step();
    check("midrst_anode", an_l, 4'hF);
    check("midrst_seg", seg_l, 7'h7F);
    rst = 1'b0;

    // Randomized stimulus held for random spans.
    for (int it = 0; it < 90; it++) begin
      kind = $urandom_range(0, 99);
      hold = $urandom_range(1, 40);
      if (kind < 60) begin
        nd = $urandom_range(0, 4);
        set_in((nd > 3) ? $urandom_range(0, 9) : 0, (nd > 2) ? $urandom_range(0, 9) : 0,
               (nd > 1) ? $urandom_range(0, 9) : 0, (nd > 0) ? $urandom_range(0, 9) : 0);
      end else if (kind < 78) begin
        set_in(15, 15, 15, 15);
        hold = $urandom_range(60, 160);
      end else if (kind < 92) begin
        set_in(0, 0, 0, 0);
        case ($urandom_range(0, 3))
          0: b0 = 4'($urandom_range(10, 15));
          1: b1 = 4'($urandom_range(10, 15));
          2: b2 = 4'($urandom_range(10, 15));
          default: b3 = 4'($urandom_range(10, 15));
        endcase
      end else begin
        rst = 1'b1;
        hold = $urandom_range(1, 3);
      end
      for (int c = 0; c < hold; c++) step();
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
